// File: rtl/pe_array_sequencer_pkg.sv
// Shared types and default sizing for the PE array sequencer.
package pe_array_sequencer_pkg;

  localparam int unsigned FILT_ROWS_DEF = 3;
  localparam int unsigned DIAGS_DEF     = 5;
  localparam int unsigned FILT_LEN_DEF  = 3;
  localparam int unsigned IFMAP_LEN_DEF = 5;
  localparam int unsigned START_GAP_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_FILT  = 3'd1,
    S_LOAD_IFMAP = 3'd2,
    S_START      = 3'd3,
    S_WAIT       = 3'd4,
    S_DONE       = 3'd5
  } seq_state_t;

  // Bits needed to hold a count of 0..n
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Byte-stream handshake between the chip byte interface and the sequencer.
interface pe_array_sequencer_if;
  logic in_valid;
  logic in_ready;

  modport master (output in_valid, input in_ready);
  modport slave  (input in_valid, output in_ready);
endinterface

// File: rtl/pe_array_sequencer_seq_beat_counter.sv
// Up-counter that returns to zero after reaching limit_i; last_o flags the terminal count.
module seq_beat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         last_o,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last_o  = (cnt_q == limit_i);
  assign count_o = cnt_q;

  // Clear dominates; increment wraps to zero at the terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one convolution pass on the 3x3 row-stationary PE array:
// filter rows, ifmap diagonals, start_conv per diagonal, then waits for the bottom-row psums.
// Optional build macro FILTER_REUSE_EN adds reuse_filt_i to skip reloading filters.
module pe_array_sequencer
  import pe_array_sequencer_pkg::*;
#(
  parameter int unsigned FILT_ROWS = FILT_ROWS_DEF,
  parameter int unsigned DIAGS     = DIAGS_DEF,
  parameter int unsigned FILT_LEN  = FILT_LEN_DEF,
  parameter int unsigned IFMAP_LEN = IFMAP_LEN_DEF,
  parameter int unsigned START_GAP = START_GAP_DEF
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start_i,
`ifdef FILTER_REUSE_EN
  input  logic                 reuse_filt_i,
`endif
  pe_array_sequencer_if.slave  in_if,
  input  logic [2:0]           psum_valid_i,
  output logic [DIAGS-1:0]     PERead,
  output logic [DIAGS-1:0]     PEStart,
  output logic [FILT_ROWS-1:0] filtRead,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned BW = cnt_w(max2(FILT_LEN, IFMAP_LEN));
  localparam int unsigned IW = cnt_w(max2(FILT_ROWS, DIAGS));
  localparam int unsigned GW = cnt_w(START_GAP);

  seq_state_t state_q, state_d;

  logic          accept;
  logic          load_done;
  logic [BW-1:0] beat_limit;
  logic [IW-1:0] idx_limit;
  logic [GW-1:0] gap_limit;
  logic          beat_clr, beat_inc, beat_last;
  logic          idx_clr, idx_inc, idx_last;
  logic          gap_clr, gap_inc, gap_last;
  logic [BW-1:0] unused_beat_cnt;
  logic [IW-1:0] idx_cnt;
  logic [GW-1:0] gap_cnt;
  logic          gap_zero;
  logic [2:0]    seen_q, seen_d;
`ifdef FILTER_REUSE_EN
  logic          filt_loaded_q, filt_loaded_d;
`endif

  // A beat is taken only while one of the load states is presenting in_ready
  assign accept    = in_if.in_valid &&
                     ((state_q == S_LOAD_FILT) || (state_q == S_LOAD_IFMAP));
  assign load_done = accept && beat_last && idx_last;
  assign gap_zero  = (gap_cnt == '0);

  assign beat_limit = (state_q == S_LOAD_FILT) ? BW'(FILT_LEN - 1)  : BW'(IFMAP_LEN - 1);
  assign idx_limit  = (state_q == S_LOAD_FILT) ? IW'(FILT_ROWS - 1) : IW'(DIAGS - 1);
  assign gap_limit  = GW'(START_GAP - 1);

  seq_beat_counter #(.W(BW)) u_beat_cnt (
    .clk     (clk),
    .nRST    (nRST),
    .clr_i   (beat_clr),
    .inc_i   (beat_inc),
    .limit_i (beat_limit),
    .last_o  (beat_last),
    .count_o (unused_beat_cnt)
  );

  // Row index in LOAD_FILT, diagonal index in LOAD_IFMAP and START
  seq_beat_counter #(.W(IW)) u_idx_cnt (
    .clk     (clk),
    .nRST    (nRST),
    .clr_i   (idx_clr),
    .inc_i   (idx_inc),
    .limit_i (idx_limit),
    .last_o  (idx_last),
    .count_o (idx_cnt)
  );

  seq_beat_counter #(.W(GW)) u_gap_cnt (
    .clk     (clk),
    .nRST    (nRST),
    .clr_i   (gap_clr),
    .inc_i   (gap_inc),
    .limit_i (gap_limit),
    .last_o  (gap_last),
    .count_o (gap_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef FILTER_REUSE_EN
          state_d = (reuse_filt_i && filt_loaded_q) ? S_LOAD_IFMAP : S_LOAD_FILT;
`else
          state_d = S_LOAD_FILT;
`endif
        end
      end
      S_LOAD_FILT:  if (load_done) state_d = S_LOAD_IFMAP;
      S_LOAD_IFMAP: if (load_done) state_d = S_START;
      S_START:      if (gap_zero && idx_last) state_d = S_WAIT;
      S_WAIT:       if ((seen_q | psum_valid_i) == 3'b111) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output and counter-control decode from state plus counters
  always_comb begin
    in_if.in_ready = 1'b0;
    busy_o         = (state_q != S_IDLE);
    done_o         = 1'b0;
    filtRead       = '0;
    PERead         = '0;
    PEStart        = '0;
    beat_clr       = 1'b1;
    beat_inc       = 1'b0;
    idx_clr        = 1'b1;
    idx_inc        = 1'b0;
    gap_clr        = 1'b1;
    gap_inc        = 1'b0;
    unique case (state_q)
      S_LOAD_FILT: begin
        in_if.in_ready = 1'b1;
        beat_clr       = 1'b0;
        idx_clr        = 1'b0;
        beat_inc       = accept;
        idx_inc        = accept && beat_last;
        for (int unsigned i = 0; i < FILT_ROWS; i++) begin
          filtRead[i] = accept && (idx_cnt == IW'(i));
        end
      end
      S_LOAD_IFMAP: begin
        in_if.in_ready = 1'b1;
        beat_clr       = 1'b0;
        idx_clr        = 1'b0;
        beat_inc       = accept;
        idx_inc        = accept && beat_last;
        for (int unsigned i = 0; i < DIAGS; i++) begin
          PERead[i] = accept && (idx_cnt == IW'(i));
        end
      end
      S_START: begin
        idx_clr = 1'b0;
        gap_clr = 1'b0;
        gap_inc = 1'b1;
        idx_inc = gap_last;
        for (int unsigned i = 0; i < DIAGS; i++) begin
          PEStart[i] = gap_zero && (idx_cnt == IW'(i));
        end
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Sticky psum tracking, restarted with each accepted pass request
  always_comb begin
    seen_d = seen_q;
    if ((state_q == S_IDLE) && start_i) begin
      seen_d = 3'b000;
    end else if ((state_q == S_START) || (state_q == S_WAIT)) begin
      seen_d = seen_q | psum_valid_i;
    end
  end

`ifdef FILTER_REUSE_EN
  // Filters stay valid in the array once a full filter load has finished
  always_comb begin
    filt_loaded_d = filt_loaded_q;
    if ((state_q == S_LOAD_FILT) && load_done) filt_loaded_d = 1'b1;
  end
`endif

  // Sticky bit registers
  always_ff @(posedge clk) begin
    if (!nRST) begin
      seen_q        <= 3'b000;
`ifdef FILTER_REUSE_EN
      filt_loaded_q <= 1'b0;
`endif
    end else begin
      seen_q        <= seen_d;
`ifdef FILTER_REUSE_EN
      filt_loaded_q <= filt_loaded_d;
`endif
    end
  end

endmodule
